// File: rtl/display_timing.sv
// Raster timing source: registered sx/sy/de/syncs/strobes, decoded from next-state counters.
// Optional colour bars when DISPLAY_TIMING_PATTERN_EN is defined; en=0 freezes the raster.
module display_timing #(
  parameter int CORDW  = 11,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  input  logic             en,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             line,
  output logic             frame
`ifdef DISPLAY_TIMING_PATTERN_EN
  ,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b
`endif
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_MAX  = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_MAX  = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
  localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
  localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);

  logic [CORDW-1:0] r_sx, r_sy;
  logic             r_de, r_hsync, r_vsync, r_line, r_frame;

  logic [CORDW-1:0] w_sx_nxt, w_sy_nxt;
  logic             w_h_wrap, w_de_nxt, w_hs_act, w_vs_act;

  // Everything registered below is decoded from where the counters go next,
  // so position, syncs and strobes for a pixel land in the same cycle.
  always_comb begin
    w_h_wrap = (r_sx == H_MAX);
    w_sx_nxt = w_h_wrap ? '0 : r_sx + 1'b1;
    w_sy_nxt = r_sy;
    if (w_h_wrap) w_sy_nxt = (r_sy == V_MAX) ? '0 : r_sy + 1'b1;
    w_de_nxt = (w_sx_nxt < H_ACT) && (w_sy_nxt < V_ACT);
    w_hs_act = (w_sx_nxt >= HS_BEG) && (w_sx_nxt < HS_END);
    w_vs_act = (w_sy_nxt >= VS_BEG) && (w_sy_nxt < VS_END);
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_sx    <= H_MAX;
      r_sy    <= V_MAX;
      r_de    <= 1'b0;
      r_hsync <= ~H_POL;
      r_vsync <= ~V_POL;
      r_line  <= 1'b0;
      r_frame <= 1'b0;
    end else if (en) begin
      r_sx    <= w_sx_nxt;
      r_sy    <= w_sy_nxt;
      r_de    <= w_de_nxt;
      r_hsync <= w_hs_act ? H_POL : ~H_POL;
      r_vsync <= w_vs_act ? V_POL : ~V_POL;
      r_line  <= (w_sx_nxt == '0);
      r_frame <= (w_sx_nxt == '0) && (w_sy_nxt == '0);
    end else begin
      r_line  <= 1'b0;
      r_frame <= 1'b0;
    end
  end

  assign sx    = r_sx;
  assign sy    = r_sy;
  assign de    = r_de;
  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign line  = r_line;
  assign frame = r_frame;

`ifdef DISPLAY_TIMING_PATTERN_EN
  // Narrow test rasters (H_RES < 8) fall back to one-pixel bars.
  localparam int               BAR_W   = (H_RES / 8 > 0) ? H_RES / 8 : 1;
  localparam logic [CORDW-1:0] BAR_DIV = CORDW'(BAR_W);
  localparam logic [CORDW-1:0] BAR_TOP = CORDW'(7);

  logic [CORDW-1:0] w_bar_raw;
  logic [2:0]       w_bar;
  logic [7:0]       r_r, r_g, r_b;

  always_comb begin
    w_bar_raw = w_sx_nxt / BAR_DIV;
    w_bar     = (w_bar_raw > BAR_TOP) ? 3'd7 : w_bar_raw[2:0];
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_r <= 8'h00;
      r_g <= 8'h00;
      r_b <= 8'h00;
    end else if (en) begin
      r_r <= w_de_nxt ? {8{w_bar[2]}} : 8'h00;
      r_g <= w_de_nxt ? {8{w_bar[1]}} : 8'h00;
      r_b <= w_de_nxt ? {8{w_bar[0]}} : 8'h00;
    end
  end

  assign r = r_r;
  assign g = r_g;
  assign b = r_b;
`endif

endmodule

// File: tb/tb_display_timing.sv
// Bench for display_timing on a small raster, checked against a linear pixel-index model.
module tb_display_timing;

  localparam int CORDW = 11;
  localparam int HRES = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VRES = 4, VFP = 1, VSY = 1, VBP = 1;
  localparam int HT = HRES + HFP + HSY + HBP;  // 14
  localparam int VT = VRES + VFP + VSY + VBP;  // 7
  localparam int NPIX = HT * VT;               // 98

  logic             clk_pix = 1'b0;
  logic             rst_pix_n = 1'b0;
  logic             en = 1'b0;
  logic [CORDW-1:0] sx, sy;
  logic             de, hsync, vsync, line, frame;
`ifdef DISPLAY_TIMING_PATTERN_EN
  logic [7:0]       r, g, b;
`endif

  display_timing #(
    .CORDW(CORDW), .H_RES(HRES), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_RES(VRES), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .en(en),
    .sx(sx), .sy(sy), .de(de), .hsync(hsync), .vsync(vsync),
    .line(line), .frame(frame)
`ifdef DISPLAY_TIMING_PATTERN_EN
    , .r(r), .g(g), .b(b)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  int n_cmp = 0;
  int n_err = 0;

  // Model: raster position as a single pixel index into the frame, plus
  // whether the latest edge advanced it (strobes only fire on advancing edges).
  int pos;
  bit advanced;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    pos = NPIX - 1;
    advanced = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int ex, ey, k;
    logic [31:0] e_rgb;
    ex = pos % HT;
    ey = pos / HT;
    check({tag, ".sx"}, 32'(sx), ex);
    check({tag, ".sy"}, 32'(sy), ey);
    check({tag, ".de"}, 32'(de), (ex < HRES && ey < VRES) ? 1 : 0);
    check({tag, ".hsync"}, 32'(hsync), (ex >= HRES + HFP && ex < HRES + HFP + HSY) ? 0 : 1);
    check({tag, ".vsync"}, 32'(vsync), (ey >= VRES + VFP && ey < VRES + VFP + VSY) ? 0 : 1);
    check({tag, ".line"}, 32'(line), (advanced && ex == 0) ? 1 : 0);
    check({tag, ".frame"}, 32'(frame), (advanced && pos == 0) ? 1 : 0);
`ifdef DISPLAY_TIMING_PATTERN_EN
    k = (ex / (HRES / 8) > 7) ? 7 : ex / (HRES / 8);
    e_rgb = 0;
    if (ex < HRES && ey < VRES)
      e_rgb = (((k >> 2) & 1) ? 32'hFF0000 : 0) | (((k >> 1) & 1) ? 32'h00FF00 : 0)
            | ((k & 1) ? 32'h0000FF : 0);
    check({tag, ".rgb"}, {8'h00, r, g, b}, e_rgb);
`else
    k = 0;
    e_rgb = 0;
`endif
  endtask

  // Called at a negedge: drive en, take one edge, compare at the next negedge.
  task automatic step(input bit e, input string tag);
    en = e;
    @(posedge clk_pix);
    if (e) pos = (pos + 1) % NPIX;
    advanced = e;
    @(negedge clk_pix);
    check_all(tag);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < NPIX && pos != target; i++) step(1'b1, "run");
    check("run_to.reached", pos, target);
  endtask

  // Assert reset between edges, check it takes effect before the next edge,
  // then release synchronously at a negedge.
  task automatic mid_reset(input string tag);
    #2 rst_pix_n = 1'b0;
    model_reset();
    #1 check_all({tag, ".async"});
    @(negedge clk_pix);
    check_all({tag, ".held"});
    rst_pix_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_pix);
    @(negedge clk_pix);
    check_all("reset");
    rst_pix_n = 1'b1;

    step(1'b1, "first");
    for (int i = 0; i < NPIX + 2; i++) step(1'b1, "frame");

    run_to(NPIX - 1);
    for (int i = 0; i < 5; i++) step(1'b0, "hold");
    step(1'b1, "resume");

    run_to(2 * HT + 5);
    mid_reset("midrst");
    step(1'b1, "restart");

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) mid_reset("rndrst");
      step($urandom_range(0, 3) != 0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
